fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Program-counter sequencer and fetch controller for the instruction ROM.
//   Drives the ROM word address, applies redirects from branch/jump resolution,
//   and vectors to the illop/xadr handlers on interrupts and fetch exceptions.
//   Holds the kernel-mode bit (PC[31]) and the saved return address (EPC).
//   Sits between the decode/branch logic and the ROM.
// PARAMETERS
//   RESET_PC  32'h8000_0000  PC after reset (kernel mode, ROM word 0)
//   ILLOP_PC  32'h8000_0004  vector for interrupts and illegal opcodes (word 1)
//   XADR_PC   32'h8000_0008  vector for bad fetch addresses (word 2)
// PORTS
//   clk             in   1   clock, rising edge
//   reset           in   1   synchronous, active-high
//   stall           in   1   hold PC and state; instr_valid forced low
//   redirect_valid  in   1   branch/jump/jr taken this cycle
//   redirect_pc     in   32  redirect target
//   irq             in   1   level interrupt request (timer)
//   illop           in   1   decoder flags current instruction undefined
//   rom_addr        out  32  fetch address (= PC); ROM indexes rom_addr[6:2]
//   instr_valid     out  1   ROM data at rom_addr is a live instruction
//   kernel          out  1   = PC[31]
//   epc             out  32  saved return address
//   int_ack         out  1   one-cycle pulse when irq is taken
// BEHAVIOUR
//   Reset: pc=RESET_PC, epc=0, int_ack=0, instr_valid=0, state=BOOT.
//   States: BOOT -> RUN (unconditional, 1 cycle); RUN -> FLUSH on any redirect
//     or vector; FLUSH -> RUN (1 cycle). FLUSH: pc held, instr_valid=0.
//   instr_valid = (state==RUN) & ~stall. Combinational, no extra latency.
//   RUN with stall=1: pc, epc, state unchanged; illop/irq/redirect ignored;
//     int_ack=0. irq is level, so it is taken once stall drops.
//   RUN, instr_valid=1, next-PC priority (highest first):
//     1 illop                       : pc<=ILLOP_PC, epc<=pc+4
//     2 bad redirect (see below)    : pc<=XADR_PC,  epc<=pc
//     3 irq & ~kernel               : pc<=ILLOP_PC, epc<=(redirect_valid ?
//                                     redirect_pc : pc+4), int_ack<=1
//     4 redirect_valid              : pc<=redirect_pc
//     5 otherwise                   : pc<={pc[31], pc[30:0]+31'd4}
//   Vectors (1-3) and redirect (4) enter FLUSH; case 5 stays in RUN.
//   Bad redirect: redirect_valid & (redirect_pc[1:0]!=0 |
//     (~kernel & redirect_pc[31])). User code cannot set the kernel bit.
//   Kernel may clear PC[31] via redirect (return from handler).
//   Sequential increment never changes PC[31]; bits 30:0 wrap mod 2^31.
//   irq masked while kernel=1; no latch, request must still be high in user mode.
//   illop + irq same cycle: illop taken, irq left pending (masked in kernel).
//   int_ack high exactly the cycle after the vector decision, else 0.
//   reset mid-FLUSH or mid-stall: reset wins, BOOT next cycle.
//   epc only written on vectors 1-3; otherwise holds.
// TESTING
//   Reset 2 cycles, release -> BOOT 1 cycle (valid=0), then rom_addr
//     0x80000000, 0x80000004... valid=1 each RUN cycle.
//   At pc=0x0000_0010 assert redirect 0x0000_0030 -> next pc 0x30, one FLUSH
//     cycle valid=0, then RUN at 0x30, next 0x34.
//   User pc=0x0000_0020, irq=1 -> pc=0x80000004, epc=0x24, int_ack=1 for 1
//     cycle; irq still high in kernel -> no second ack.
//   User pc=0x18, illop=1 & irq=1 -> pc=0x80000004, epc=0x1C, int_ack=0.
//   User redirect 0x8000_0040 or 0x0000_0042 -> pc=0x80000008, epc=old pc.
//   stall=1 for 3 cycles at pc=0x0C with irq=1 -> pc held, valid=0, no ack;
//     stall drops -> irq taken, epc=0x10. Reset during stall -> pc=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle between decode/branch logic and the PC sequencer.
// master = fetch_ctrl (drives the ROM address and status), slave = decode/branch side.
interface fetch_ctrl_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        irq;
    logic        illop;
    logic [31:0] rom_addr;
    logic        instr_valid;
    logic        kernel;
    logic [31:0] epc;
    logic        int_ack;

    modport master (
        input  stall, redirect_valid, redirect_pc, irq, illop,
        output rom_addr, instr_valid, kernel, epc, int_ack
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, irq, illop,
        input  rom_addr, instr_valid, kernel, epc, int_ack
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the instruction ROM: redirects, illop/xadr
// vectoring, interrupt entry, kernel bit (PC[31]) and saved return address.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_int_ack;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_epc_nxt;
    logic        w_int_ack_nxt;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_plus4;
    logic        w_kernel;
    logic        w_valid;
    logic        w_bad_redir;

    assign w_kernel    = r_pc[31];
    assign w_valid     = (r_state == RUN) & ~bus.stall;
    assign w_pc_plus4  = r_pc + 32'd4;
    // Sequential fetch keeps the mode bit; only the low 31 bits wrap.
    assign w_pc_seq    = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_bad_redir = bus.redirect_valid &
                         ((bus.redirect_pc[1:0] != 2'b00) |
                          (~w_kernel & bus.redirect_pc[31]));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_epc     <= '0;
            r_int_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_epc     <= w_epc_nxt;
            r_int_ack <= w_int_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_epc_nxt     = r_epc;
        w_int_ack_nxt = 1'b0;
        case (r_state)
            BOOT:  w_state_nxt = RUN;
            FLUSH: w_state_nxt = RUN;
            RUN: begin
                if (w_valid) begin
                    w_state_nxt = FLUSH;
                    if (bus.illop) begin
                        w_pc_nxt  = ILLOP_PC;
                        w_epc_nxt = w_pc_plus4;
                    end else if (w_bad_redir) begin
                        w_pc_nxt  = XADR_PC;
                        w_epc_nxt = r_pc;
                    end else if (bus.irq & ~w_kernel) begin
                        w_pc_nxt      = ILLOP_PC;
                        w_epc_nxt     = bus.redirect_valid ? bus.redirect_pc : w_pc_plus4;
                        w_int_ack_nxt = 1'b1;
                    end else if (bus.redirect_valid) begin
                        w_pc_nxt = bus.redirect_pc;
                    end else begin
                        w_pc_nxt    = w_pc_seq;
                        w_state_nxt = RUN;
                    end
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    assign bus.rom_addr    = r_pc;
    assign bus.instr_valid = w_valid;
    assign bus.kernel      = w_kernel;
    assign bus.epc         = r_epc;
    assign bus.int_ack     = r_int_ack;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, redirects, vectors, stall and reset.
module tb_fetch_ctrl;
    logic clk;
    logic reset;
    int unsigned n_cmp;
    int unsigned n_err;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC(32'h8000_0000),
        .ILLOP_PC(32'h8000_0004),
        .XADR_PC (32'h8000_0008)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [31:0] addr, input logic valid, input logic ack);
        check_eq({tag, ".addr"},  bus.rom_addr, addr);
        check_eq({tag, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, valid});
        check_eq({tag, ".ack"},   {31'd0, bus.int_ack}, {31'd0, ack});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic v, input logic [31:0] pc);
        bus.redirect_valid = v;
        bus.redirect_pc    = pc;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.irq   = 1'b0;
        bus.illop = 1'b0;
        redir(1'b0, '0);

        tick(); tick();
        check_st("rst", 32'h8000_0000, 1'b0, 1'b0);
        check_eq("rst.epc", bus.epc, 32'h0);
        check_eq("rst.kernel", {31'd0, bus.kernel}, 32'd1);
        reset = 1'b0;
        #1;
        check_st("boot", 32'h8000_0000, 1'b0, 1'b0);
        tick();
        check_st("run0", 32'h8000_0000, 1'b1, 1'b0);
        tick();
        check_st("run1", 32'h8000_0004, 1'b1, 1'b0);

        // kernel returns to user 0x10, then user redirect to 0x30
        redir(1'b1, 32'h0000_0010);
        tick(); redir(1'b0, '0);
        check_st("ret.flush", 32'h0000_0010, 1'b0, 1'b0);
        check_eq("ret.kernel", {31'd0, bus.kernel}, 32'd0);
        tick();
        check_st("ret.run", 32'h0000_0010, 1'b1, 1'b0);
        redir(1'b1, 32'h0000_0030);
        tick(); redir(1'b0, '0);
        check_st("br.flush", 32'h0000_0030, 1'b0, 1'b0);
        tick();
        check_st("br.run", 32'h0000_0030, 1'b1, 1'b0);
        tick();
        check_st("br.seq", 32'h0000_0034, 1'b1, 1'b0);
        check_eq("br.epc", bus.epc, 32'h0);

        // user irq at 0x20
        redir(1'b1, 32'h0000_0020);
        tick(); redir(1'b0, '0);
        tick();
        check_st("irq.pre", 32'h0000_0020, 1'b1, 1'b0);
        bus.irq = 1'b1;
        tick();
        check_st("irq.take", 32'h8000_0004, 1'b0, 1'b1);
        check_eq("irq.epc", bus.epc, 32'h0000_0024);
        tick();
        check_st("irq.k0", 32'h8000_0004, 1'b1, 1'b0);
        tick();
        check_st("irq.k1", 32'h8000_0008, 1'b1, 1'b0);
        bus.irq = 1'b0;

        // illop and irq together in user mode
        redir(1'b1, 32'h0000_0018);
        tick(); redir(1'b0, '0);
        tick();
        check_st("ill.pre", 32'h0000_0018, 1'b1, 1'b0);
        bus.illop = 1'b1;
        bus.irq   = 1'b1;
        tick();
        bus.illop = 1'b0;
        bus.irq   = 1'b0;
        check_st("ill.take", 32'h8000_0004, 1'b0, 1'b0);
        check_eq("ill.epc", bus.epc, 32'h0000_001C);

        // user tries to enter kernel space
        tick();
        redir(1'b1, 32'h0000_0040);
        tick(); redir(1'b0, '0);
        tick();
        check_st("xk.pre", 32'h0000_0040, 1'b1, 1'b0);
        redir(1'b1, 32'h8000_0040);
        tick(); redir(1'b0, '0);
        check_st("xk.take", 32'h8000_0008, 1'b0, 1'b0);
        check_eq("xk.epc", bus.epc, 32'h0000_0040);

        // misaligned user redirect
        tick();
        redir(1'b1, 32'h0000_0050);
        tick(); redir(1'b0, '0);
        tick();
        check_st("xa.pre", 32'h0000_0050, 1'b1, 1'b0);
        redir(1'b1, 32'h0000_0042);
        tick(); redir(1'b0, '0);
        check_st("xa.take", 32'h8000_0008, 1'b0, 1'b0);
        check_eq("xa.epc", bus.epc, 32'h0000_0050);

        // stall holds everything with irq pending
        tick();
        redir(1'b1, 32'h0000_000C);
        tick(); redir(1'b0, '0);
        tick();
        bus.stall = 1'b1;
        bus.irq   = 1'b1;
        #1;
        check_st("stl.0", 32'h0000_000C, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_st($sformatf("stl.%0d", i), 32'h0000_000C, 1'b0, 1'b0);
            check_eq($sformatf("stl.epc%0d", i), bus.epc, 32'h0000_0050);
        end
        bus.stall = 1'b0;
        #1;
        check_st("stl.rel", 32'h0000_000C, 1'b1, 1'b0);
        tick();
        bus.irq = 1'b0;
        check_st("stl.irq", 32'h8000_0004, 1'b0, 1'b1);
        check_eq("stl.epc", bus.epc, 32'h0000_0010);

        // reset during stall
        tick();
        bus.stall = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        bus.stall = 1'b0;
        #1;
        check_st("rs.boot", 32'h8000_0000, 1'b0, 1'b0);
        check_eq("rs.epc", bus.epc, 32'h0);
        tick();
        check_st("rs.run", 32'h8000_0000, 1'b1, 1'b0);

        // low 31 bits wrap without touching the mode bit
        redir(1'b1, 32'h7FFF_FFFC);
        tick(); redir(1'b0, '0);
        tick();
        check_st("wr.pre", 32'h7FFF_FFFC, 1'b1, 1'b0);
        tick();
        check_st("wr.post", 32'h0000_0000, 1'b1, 1'b0);
        check_eq("wr.kernel", {31'd0, bus.kernel}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
